axi_lite_regfile: RTL

//  Parametrised AXI4-Lite slave register file; next generation of our AXI-Lite slave.

---
 rtl/axi_lite_pkg.sv | 29 ++
 rtl/axi_lite_regfile_if.sv | 37 +++
 rtl/axi_lite_strb_reg.sv | 28 ++
 rtl/axi_lite_regfile.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      WR_IDLE,
      WR_RESP
   } wr_state_t;

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_t;

   // Sized for the widest legal bus (64 bits); callers zero-extend and truncate.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
      logic [63:0] r;
      for (int b = 0; b < 8; b++)
         r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      return r;
   endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register file slave.
interface axi_lite_regfile_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_strb_reg.sv
// One register with per-byte write enables, cleared by synchronous reset.
module axi_lite_strb_reg
   import axi_lite_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                we_i,
   input  logic [DATA_W/8-1:0] strb_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   q_o
);
   logic [DATA_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (we_i)
         q_d = DATA_W'(strb_merge(64'(q_q), 64'(wdata_i), 8'(strb_i)));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) q_q <= '0;
      else         q_q <= q_d;
   end

   assign q_o = q_q;
endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: RW control registers with byte strobes, RO status
// registers sampled from fabric, independent write and read state machines.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int unsigned         DATA_W   = 32,
   parameter int unsigned         ADDR_W   = 5,
   parameter int unsigned         NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   axi_lite_regfile_if.slave            s,
   output logic [NUM_REGS*DATA_W-1:0]   ctrl_out,
   input  logic [NUM_REGS*DATA_W-1:0]   status_in,
   output logic [NUM_REGS-1:0]          wr_pulse
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFS    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = ADDR_W - OFS;

   // Readies stay low while in reset and rise the cycle after release.
   logic rdy_en_q;

   wr_state_t            wr_q, wr_d;
   logic                 aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [IDX_W-1:0]     awidx_q, awidx_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [STRB_W-1:0]    wstrb_q, wstrb_d;
   resp_t                bresp_q, bresp_d;
   logic [NUM_REGS-1:0]  wr_pulse_q, wr_pulse_d;

   rd_state_t            rd_q, rd_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   resp_t                rresp_q, rresp_d;

   logic                 awready, wready, arready;
   logic                 aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
   logic [IDX_W-1:0]     widx, ridx;
   logic [DATA_W-1:0]    wdat, rd_val;
   logic [STRB_W-1:0]    wstb;
   logic [NUM_REGS-1:0]  wsel, we;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs;

   assign awready = rdy_en_q && (wr_q == WR_IDLE) && !aw_held_q;
   assign wready  = rdy_en_q && (wr_q == WR_IDLE) && !w_held_q;
   assign arready = rdy_en_q && (rd_q == RD_IDLE);
   assign aw_hs   = s.awvalid && awready;
   assign w_hs    = s.wvalid && wready;
   assign ar_hs   = s.arvalid && arready;

   // A channel that already handshook supplies its latched copy; otherwise the live bus.
   assign widx = aw_held_q ? awidx_q : s.awaddr[ADDR_W-1:OFS];
   assign wdat = w_held_q  ? wdata_q : s.wdata;
   assign wstb = w_held_q  ? wstrb_q : s.wstrb;
   assign ridx = s.araddr[ADDR_W-1:OFS];

   assign commit = (wr_q == WR_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign wr_ok  = |(wsel & ~RO_MASK);
   assign we     = commit ? (wsel & ~RO_MASK) : '0;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      assign wsel[g] = (widx == IDX_W'(g));
      axi_lite_strb_reg #(.DATA_W(DATA_W)) u_reg (
         .clk_i   (aclk),
         .rst_ni  (aresetn),
         .we_i    (we[g]),
         .strb_i  (wstb),
         .wdata_i (wdat),
         .q_o     (regs[g])
      );
   end

   always_comb begin
      wr_d       = wr_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awidx_d    = awidx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      wr_pulse_d = '0;
      case (wr_q)
         WR_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awidx_d   = s.awaddr[ADDR_W-1:OFS];
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = s.wdata;
               wstrb_d  = s.wstrb;
            end
            if (commit) begin
               wr_d       = WR_RESP;
               bresp_d    = wr_ok ? OKAY : SLVERR;
               wr_pulse_d = we;
            end
         end
         WR_RESP: begin
            if (s.bready) begin
               wr_d      = WR_IDLE;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
            end
         end
         default: wr_d = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_val = '0;
      rd_ok  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ridx == IDX_W'(i)) begin
            rd_ok  = 1'b1;
            rd_val = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs[i];
         end
      end
   end

   always_comb begin
      rd_d    = rd_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      case (rd_q)
         RD_IDLE: begin
            if (ar_hs) begin
               rd_d    = RD_RESP;
               rdata_d = rd_val;
               rresp_d = rd_ok ? OKAY : SLVERR;
            end
         end
         RD_RESP: if (s.rready) rd_d = RD_IDLE;
         default: rd_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rdy_en_q   <= 1'b0;
         wr_q       <= WR_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awidx_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= OKAY;
         wr_pulse_q <= '0;
         rd_q       <= RD_IDLE;
         rdata_q    <= '0;
         rresp_q    <= OKAY;
      end else begin
         rdy_en_q   <= 1'b1;
         wr_q       <= wr_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awidx_q    <= awidx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         rd_q       <= rd_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign s.awready = awready;
   assign s.wready  = wready;
   assign s.bvalid  = (wr_q == WR_RESP);
   assign s.bresp   = bresp_q;
   assign s.arready = arready;
   assign s.rvalid  = (rd_q == RD_RESP);
   assign s.rdata   = rdata_q;
   assign s.rresp   = rresp_q;
   assign ctrl_out  = regs;
   assign wr_pulse  = wr_pulse_q;

   logic unused_ok;
   assign unused_ok = ^{s.awprot, s.arprot, s.awaddr[OFS-1:0], s.araddr[OFS-1:0], status_in};
endmodule
